// File: rtl/aes_lane_pkg.sv
// rtl/aes_lane_pkg.sv - shared byte type, pipeline latency and FIPS-197 S-box table
package aes_lane_pkg;

  typedef logic [7:0] byte_t;

  localparam int LAT = 2;

  // Index 0 is the leftmost byte of the first row, so SBOX[x] is the textbook lookup.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic byte_t sbox_byte(input byte_t x);
    return SBOX[x];
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// rtl/aes_sbox_lane.sv - one byte lane: key-add for stage 1, S-box/bypass select for stage 2
module aes_sbox_lane
  import aes_lane_pkg::*;
(
  input  logic [7:0] in_data,
  input  logic [7:0] in_key,
  output logic [7:0] x_out,
  input  logic [7:0] s1_x,
  input  logic       s1_mode,
  output logic [7:0] y_out
);

  always_comb begin
    x_out = in_data ^ in_key;
    y_out = s1_mode ? s1_x : sbox_byte(s1_x);
  end

endmodule

// File: rtl/aes_subkey_lane_pipe.sv
// rtl/aes_subkey_lane_pipe.sv - 2-stage elastic AddRoundKey + SubBytes over NUM_BYTES lanes
module aes_subkey_lane_pipe
  import aes_lane_pkg::*;
#(
  parameter int NUM_BYTES = 16,
  parameter int CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [8*NUM_BYTES-1:0] in_data,
  input  logic [8*NUM_BYTES-1:0] in_key,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_data,
  output logic [CNT_W-1:0]       beat_cnt
);

  localparam int W = 8 * NUM_BYTES;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_mode_q, s1_mode_d;
  logic [W-1:0]     s1_x_q, s1_x_d;
  logic             s2_valid_q, s2_valid_d;
  logic [W-1:0]     s2_data_q, s2_data_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [W-1:0] x_lane;
  logic [W-1:0] y_lane;
  logic         s1_adv;
  logic         s2_adv;

  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
    aes_sbox_lane u_lane (
      .in_data (in_data[8*i +: 8]),
      .in_key  (in_key[8*i +: 8]),
      .x_out   (x_lane[8*i +: 8]),
      .s1_x    (s1_x_q[8*i +: 8]),
      .s1_mode (s1_mode_q),
      .y_out   (y_lane[8*i +: 8])
    );
  end

  // A stage may load whenever it is empty or its content leaves this cycle.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_x_d     = s1_x_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    beat_cnt_d = beat_cnt_q + CNT_W'(s2_valid_q && out_ready);
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_x_d    = x_lane;
        s1_mode_d = in_mode;
      end
    end
    // Payload only moves with a real beat so out_data holds its last value when idle.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = y_lane;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_x_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s1_x_q     <= s1_x_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_aes_subkey_lane_pipe.sv
// tb/tb_aes_subkey_lane_pipe.sv - directed and randomised checks of the lane pipe
module tb_aes_subkey_lane_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 1-lane instance with a 4-bit counter
  logic       a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_in_key, a_out_data;
  logic [3:0] a_beat_cnt;

  // 16-lane instance
  logic         b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready;
  logic [127:0] b_in_data, b_in_key, b_out_data;
  logic [7:0]   b_beat_cnt;

  aes_subkey_lane_pipe #(.NUM_BYTES(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode),
    .in_data(a_in_data), .in_key(a_in_key),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .beat_cnt(a_beat_cnt)
  );

  aes_subkey_lane_pipe #(.NUM_BYTES(16), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
    .in_data(b_in_data), .in_key(b_in_key),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .beat_cnt(b_beat_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  // Hand-picked S-box pairs from the FIPS-197 table
  logic [7:0] xs[8] = '{8'h00, 8'h53, 8'h19, 8'h3d, 8'he3, 8'hbe, 8'hff, 8'h01};
  logic [7:0] sb[8] = '{8'h63, 8'hed, 8'hd4, 8'h27, 8'h11, 8'hae, 8'h16, 8'h7c};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [7:0] d, input logic [7:0] k, input logic m);
    a_in_valid = v;
    a_in_data  = d;
    a_in_key   = k;
    a_in_mode  = m;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_s[16];

  initial begin
    rst_n = 1'b0;
    drive_a(0, 8'h00, 8'h00, 0);
    a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_mode = 1'b0; b_in_data = '0; b_in_key = '0; b_out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_beat_cnt", a_beat_cnt, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_in_ready", a_in_ready, 1);

    // zero data / zero key through the S-box
    a_out_ready = 1'b1;
    drive_a(1, 8'h00, 8'h00, 0);
    step();
    drive_a(0, 8'h00, 8'h00, 0);
    chk("t1_lat1_valid", a_out_valid, 0);
    step();
    chk("t1_valid", a_out_valid, 1);
    chk("t1_data", a_out_data, 8'h63);
    chk("t1_cnt_before", a_beat_cnt, 0);
    step();
    chk("t1_cnt", a_beat_cnt, 1);
    chk("t1_empty", a_out_valid, 0);

    // stall with three beats offered, mixed modes
    a_out_ready = 1'b0;
    drive_a(1, 8'h57, 8'h04, 0);
    #1 chk("t3_rdy0", a_in_ready, 1);
    step();
    drive_a(1, 8'h57, 8'h04, 1);
    #1 chk("t3_rdy1", a_in_ready, 1);
    step();
    drive_a(1, 8'h00, 8'h01, 0);
    #1 chk("t3_full_rdy", a_in_ready, 0);
    chk("t3_valid", a_out_valid, 1);
    chk("t3_sbox_57_04", a_out_data, 8'hed);
    step();
    chk("t3_hold_data", a_out_data, 8'hed);
    chk("t3_hold_rdy", a_in_ready, 0);
    step();
    chk("t3_hold_data2", a_out_data, 8'hed);
    a_out_ready = 1'b1;
    #1 chk("t3_rdy_release", a_in_ready, 1);
    step();
    drive_a(0, 8'h00, 8'h00, 0);
    chk("t3_bypass_57_04", a_out_data, 8'h53);
    chk("t3_valid2", a_out_valid, 1);
    step();
    chk("t3_third", a_out_data, 8'h7c);
    step();
    chk("t3_drained", a_out_valid, 0);
    chk("t3_cnt", a_beat_cnt, 4);

    // back-to-back stream, alternating modes, counter wrap
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) exp_s[i] = i[0] ? xs[i % 8] : sb[i % 8];
    for (int t = 0; t < 18; t++) begin
      if (t < 16) drive_a(1, xs[t % 8] ^ 8'(t * 17), 8'(t * 17), t[0]);
      else drive_a(0, 8'h00, 8'h00, 0);
      #1 if (t < 16) chk("t4_in_ready", a_in_ready, 1);
      step();
      if (t == 0) chk("t4_first_empty", a_out_valid, 0);
      if (t >= 1 && t <= 16) begin
        chk($sformatf("t4_valid_%0d", t - 1), a_out_valid, 1);
        chk($sformatf("t4_data_%0d", t - 1), a_out_data, exp_s[t - 1]);
      end
      if (t == 16) chk("t4_cnt15", a_beat_cnt, 15);
    end
    chk("t4_cnt_wrap", a_beat_cnt, 0);
    chk("t4_end_empty", a_out_valid, 0);

    // 16 lanes: FIPS-197 App. B round 1, SubBytes then bypass
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_data   = 128'h340737e0a29831318d305a88a8f64332;
    b_in_key    = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    b_in_mode   = 1'b0;
    #1 chk("t5_in_ready", b_in_ready, 1);
    step();
    b_in_mode = 1'b1;
    step();
    b_in_valid = 1'b0;
    chk("t5_valid", b_out_valid, 1);
    chk("t5_subbytes", b_out_data, 128'h3052411ee55db4b8f198bfe0ae1127d4);
    step();
    chk("t5_addkey", b_out_data, 128'h0848f8e92a8dc69a2be2f4a0bee33d19);
    step();
    chk("t5_cnt", b_beat_cnt, 2);
    chk("t5_empty", b_out_valid, 0);

    // reset with two beats in flight
    a_out_ready = 1'b0;
    drive_a(1, 8'h11, 8'h22, 0);
    step();
    drive_a(1, 8'h33, 8'h44, 1);
    step();
    drive_a(0, 8'h00, 8'h00, 0);
    chk("t6_loaded", a_out_valid, 1);
    rst_n = 1'b0;
    step();
    chk("t6_rst_valid", a_out_valid, 0);
    chk("t6_rst_cnt", a_beat_cnt, 0);
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      step();
      chk("t6_no_stale", a_out_valid, 0);
    end
    chk("t6_cnt_after", a_beat_cnt, 0);

    // random valid/ready against a queue model
    for (int t = 0; t < 400; t++) begin
      int idx;
      logic m;
      logic [7:0] k;
      idx = $urandom_range(0, 7);
      m = 1'($urandom_range(0, 1));
      k = 8'($urandom);
      drive_a(1'($urandom_range(0, 1)), xs[idx] ^ k, k, m);
      a_out_ready = 1'($urandom_range(0, 2) != 0);
      #1;
      chk("rnd_in_ready", a_in_ready, (q.size() < 2) || a_out_ready);
      if (a_out_valid && a_out_ready) begin
        if (q.size() == 0) chk("rnd_unexpected_beat", a_out_valid, 0);
        else chk("rnd_data", a_out_data, q.pop_front());
      end
      if (a_in_valid && a_in_ready) q.push_back(m ? xs[idx] : sb[idx]);
      step();
    end
    drive_a(0, 8'h00, 8'h00, 0);
    a_out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      #1;
      if (a_out_valid) begin
        if (q.size() == 0) chk("drain_unexpected_beat", a_out_valid, 0);
        else chk("drain_data", a_out_data, q.pop_front());
      end
      step();
    end
    chk("drain_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
